// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types, constants and parity helper
//
// Shared with decode and writeback.
//   REG_NUMREGS / REG_DW : default architectural register count and width
//   REG_AW               : default register address width
//   reg_addr_t           : register index at the default size
//   reg_data_t           : register value at the default size
//   REG_ZERO             : index of the hardwired-zero register x0
//   PARITY_MAXW          : widest data word parity() accepts
//   parity()             : even-parity bit of a zero-extended data word
package regfile_pkg;

    localparam int REG_NUMREGS = 32;
    localparam int REG_DW      = 32;
    localparam int REG_AW      = $clog2(REG_NUMREGS);
    localparam int PARITY_MAXW = 64;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    // Returns the bit that makes the total count of ones even. Narrower words
    // are zero-extended by the caller, which does not change their parity.
    function automatic logic parity(input logic [PARITY_MAXW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy scoreboard for pending register producers
//
// Ports:
//   clk_i        in   1               clock
//   rst_ni       in   1               asynchronous active-low reset
//   alloc_i      in   1               mark alloc_addr_i busy
//   alloc_addr_i in   AW              destination being allocated
//   rel_i        in   NWPORTS         per-port release (accepted write, never x0)
//   rel_addr_i   in   NWPORTS*AW      per-port released register
//   busy_o       out  NUMREGS         registered busy vector
//   busy_next_o  out  NUMREGS         busy vector after this cycle's alloc/release
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NUMREGS = 32,
    parameter  int NWPORTS = 2,
    localparam int AW      = $clog2(NUMREGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_i,
    input  logic [AW-1:0]         alloc_addr_i,
    input  logic [NWPORTS-1:0]    rel_i,
    input  logic [NWPORTS*AW-1:0] rel_addr_i,
    output logic [NUMREGS-1:0]    busy_o,
    output logic [NUMREGS-1:0]    busy_next_o
);

    logic [NUMREGS-1:0] busy_q;
    logic [NUMREGS-1:0] busy_next;

    // Releases are applied before the allocation so that a new producer
    // issued in the same cycle as the old one's writeback keeps the entry busy.
    always_comb begin
        busy_next = busy_q;
        for (int p = 0; p < NWPORTS; p++) begin
            if (rel_i[p]) begin
                busy_next[rel_addr_i[p*AW +: AW]] = 1'b0;
            end
        end
        if (alloc_i && (alloc_addr_i != '0)) begin
            busy_next[alloc_addr_i] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_o      = busy_q;
    assign busy_next_o = busy_next;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register bank with bypass, x0 and busy scoreboard
//
// Optional feature macro: REGFILE_PARITY_EN (per-entry even parity, perr_o).
//
// Ports:
//   clk_i        in   1                 clock
//   rst_ni       in   1                 asynchronous active-low reset
//   re_i         in   NRPORTS           per-port read enable
//   raddr_i      in   NRPORTS*AW        per-port read address
//   rdata_o      out  NRPORTS*DATAWIDTH per-port read data, 1-cycle latency
//   rbusy_o      out  NRPORTS           per-port busy flag, sampled with the read
//   we_i         in   NWPORTS           per-port write enable (higher index wins)
//   waddr_i      in   NWPORTS*AW        per-port write address
//   wdata_i      in   NWPORTS*DATAWIDTH per-port write data
//   alloc_i      in   1                 mark alloc_addr_i busy
//   alloc_addr_i in   AW                destination being allocated
//   busy_o       out  NUMREGS           scoreboard vector
//   perr_o       out  NRPORTS           read parity error (0 without REGFILE_PARITY_EN)
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int NUMREGS   = 32,
    parameter  int DATAWIDTH = 32,
    parameter  int NRPORTS   = 2,
    parameter  int NWPORTS   = 2,
    localparam int AW        = $clog2(NUMREGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NRPORTS-1:0]             re_i,
    input  logic [NRPORTS*AW-1:0]          raddr_i,
    output logic [NRPORTS*DATAWIDTH-1:0]   rdata_o,
    output logic [NRPORTS-1:0]             rbusy_o,
    input  logic [NWPORTS-1:0]             we_i,
    input  logic [NWPORTS*AW-1:0]          waddr_i,
    input  logic [NWPORTS*DATAWIDTH-1:0]   wdata_i,
    input  logic                           alloc_i,
    input  logic [AW-1:0]                  alloc_addr_i,
    output logic [NUMREGS-1:0]             busy_o,
    output logic [NRPORTS-1:0]             perr_o
);

    logic [DATAWIDTH-1:0] bank [NUMREGS];

    logic [AW-1:0]        waddr [NWPORTS];
    logic [DATAWIDTH-1:0] wdata [NWPORTS];
    logic [NWPORTS-1:0]   wen;
    logic [AW-1:0]        raddr [NRPORTS];

    logic [DATAWIDTH-1:0] rd_val [NRPORTS];
    logic [NRPORTS-1:0]   rd_byp;
    logic [DATAWIDTH-1:0] rdata_q [NRPORTS];
    logic [NRPORTS-1:0]   rbusy_q;

    logic [NUMREGS-1:0]   busy_next;

    always_comb begin
        for (int p = 0; p < NWPORTS; p++) begin
            waddr[p] = waddr_i[p*AW +: AW];
            wdata[p] = wdata_i[p*DATAWIDTH +: DATAWIDTH];
            // x0 writes are dropped here so they neither store nor release.
            wen[p]   = we_i[p] && (waddr_i[p*AW +: AW] != '0);
        end
        for (int r = 0; r < NRPORTS; r++) begin
            raddr[r] = raddr_i[r*AW +: AW];
        end
    end

    regfile_scoreboard #(
        .NUMREGS (NUMREGS),
        .NWPORTS (NWPORTS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_i      (alloc_i),
        .alloc_addr_i (alloc_addr_i),
        .rel_i        (wen),
        .rel_addr_i   (waddr_i),
        .busy_o       (busy_o),
        .busy_next_o  (busy_next)
    );

    // Ascending port order: the highest-index port's assignment lands last
    // and therefore wins on an address collision.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUMREGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NWPORTS; p++) begin
                if (wen[p]) begin
                    bank[waddr[p]] <= wdata[p];
                end
            end
        end
    end

    // Bypass mux: same priority as the bank write, x0 overrides everything.
    always_comb begin
        for (int r = 0; r < NRPORTS; r++) begin
            rd_val[r] = bank[raddr[r]];
            rd_byp[r] = 1'b0;
            for (int p = 0; p < NWPORTS; p++) begin
                if (wen[p] && (waddr[p] == raddr[r])) begin
                    rd_val[r] = wdata[p];
                    rd_byp[r] = 1'b1;
                end
            end
            if (raddr[r] == '0) begin
                rd_val[r] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NRPORTS; r++) begin
                rdata_q[r] <= '0;
            end
            rbusy_q <= '0;
        end else begin
            for (int r = 0; r < NRPORTS; r++) begin
                rdata_q[r] <= re_i[r] ? rd_val[r] : '0;
                rbusy_q[r] <= re_i[r] & busy_next[raddr[r]];
            end
        end
    end

    genvar gr;
    generate
        for (gr = 0; gr < NRPORTS; gr++) begin : g_rdata
            assign rdata_o[gr*DATAWIDTH +: DATAWIDTH] = rdata_q[gr];
        end
    endgenerate

    assign rbusy_o = rbusy_q;

`ifdef REGFILE_PARITY_EN
    logic                 par_q [NUMREGS];
    logic [NRPORTS-1:0]   rd_perr;
    logic [NRPORTS-1:0]   perr_q;

    function automatic logic par_of(input logic [DATAWIDTH-1:0] d);
        logic [PARITY_MAXW-1:0] e;
        e = '0;
        e[DATAWIDTH-1:0] = d;
        return parity(e);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUMREGS; i++) begin
                par_q[i] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < NWPORTS; p++) begin
                if (wen[p]) begin
                    par_q[waddr[p]] <= par_of(wdata[p]);
                end
            end
        end
    end

    // Bypassed data never touched the array, so there is nothing to check.
    always_comb begin
        for (int r = 0; r < NRPORTS; r++) begin
            rd_perr[r] = !rd_byp[r] && (raddr[r] != '0) &&
                         (par_of(bank[raddr[r]]) != par_q[raddr[r]]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perr_q <= '0;
        end else begin
            perr_q <= re_i & rd_perr;
        end
    end

    assign perr_o = perr_q;
`else
    logic unused_byp;
    assign unused_byp = ^rd_byp;
    assign perr_o     = '0;
`endif

endmodule
